// File: rtl/uart_pkg.sv
// Shared UART definitions for the packed TX/RX pair.
//   - RX FSM state encodings (IDLE/START/DATA/STOP)
//   - NUM_BYTES: bytes packed into one user word
//   - bps_cnt(): clocks per bit, identical on both sides of the link
package uart_pkg;

    localparam int NUM_BYTES = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    function automatic int bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_recv.sv
// Single-byte 8N1 receive core.
//   clk, rst_n  : system clock, async active-low reset
//   rxd         : raw serial input (idle high, asynchronous)
//   byte_done   : 1-cycle pulse, byte_data valid, stop bit was high
//   byte_data   : last received byte (LSB first on the wire)
//   byte_ferr   : 1-cycle pulse, stop bit sampled low, byte discarded
//   core_busy   : FSM is not in IDLE
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       byte_ferr,
    output logic       core_busy
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CW      = $clog2(BPS_CNT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BPS_CNT / 2 - 1);

    logic          rxd_d0, rxd_d1;
    logic          fall;
    logic [1:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    // Two-flop synchroniser; resets to the idle (high) line level so
    // reset release cannot look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_d0 <= 1'b1;
            rxd_d1 <= 1'b1;
        end else begin
            rxd_d0 <= rxd;
            rxd_d1 <= rxd_d0;
        end
    end

    assign fall = rxd_d1 & ~rxd_d0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            byte_ferr <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            byte_ferr <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    // Re-check the line mid start bit to reject glitches.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rxd_d1 ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    // Counter was aligned mid start bit, so each full
                    // period lands mid data bit.
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rxd_d1, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a following start edge
                    // with only one stop bit is still caught.
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rxd_d1) byte_done <= 1'b1;
                        else        byte_ferr <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_data = shift;
    assign core_busy = (state != IDLE);

endmodule

// File: rtl/p_uart_recv.sv
// Packed UART receiver: collects 8 consecutive 8N1 bytes, LSB byte first,
// into one 64-bit word.
//   sys_clk, sys_rst_n : system clock, async active-low reset
//   uart_rxd           : serial input, idle high
//   uart_dout          : last complete word (byte 0 in [7:0])
//   uart_done          : 1-cycle pulse when uart_dout was just updated
//   rx_busy            : byte in flight or partial word held (registered)
//   frame_err          : 1-cycle pulse on a low stop bit
//   word_drop          : 1-cycle pulse when a partial word is discarded
module p_uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int UART_BPS     = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   uart_rxd,
    output logic [8*NUM_BYTES-1:0] uart_dout,
    output logic                   uart_done,
    output logic                   rx_busy,
    output logic                   frame_err,
    output logic                   word_drop
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int TO_CNT  = TIMEOUT_BITS * BPS_CNT;
    localparam int IW      = $clog2(TO_CNT);
    localparam logic [IW-1:0] TO_LAST = IW'(TO_CNT - 1);

    logic       byte_done, byte_ferr, core_busy;
    logic [7:0] byte_data;

    // Only bytes 0..6 are buffered; byte 7 goes straight into uart_dout.
    logic [8*(NUM_BYTES-1)-1:0] word_buf;
    logic [2:0]                 byte_cnt;
    logic [IW-1:0]              idle_cnt;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) u_core (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .rxd       (uart_rxd),
        .byte_done (byte_done),
        .byte_data (byte_data),
        .byte_ferr (byte_ferr),
        .core_busy (core_busy)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            word_buf  <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            uart_dout <= '0;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            word_drop <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            word_drop <= 1'b0;
            rx_busy   <= core_busy | (byte_cnt != 3'd0);

            // byte_done has priority over the timeout in the same cycle.
            if (byte_done) begin
                idle_cnt <= '0;
                byte_cnt <= byte_cnt + 1'b1;   // 7 -> 0 wrap closes the word
                if (byte_cnt == 3'd7) begin
                    uart_dout <= {byte_data, word_buf};
                    uart_done <= 1'b1;
                end else begin
                    word_buf[{byte_cnt, 3'b000} +: 8] <= byte_data;
                end
            end else if (byte_ferr) begin
                frame_err <= 1'b1;
                idle_cnt  <= '0;
                if (byte_cnt != 3'd0) begin
                    word_drop <= 1'b1;
                    byte_cnt  <= '0;
                end
            end else if (byte_cnt == 3'd0) begin
                idle_cnt <= '0;
            end else if (!core_busy) begin
                if (idle_cnt == TO_LAST) begin
                    idle_cnt  <= '0;
                    byte_cnt  <= '0;
                    word_drop <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule
